// File: rtl/pc_fetch_if.sv
// pc_fetch_if: fetch-stage bundle between the PC sequencer and control, incrementer and instruction memory.
// fetch_count exists only when FETCH_COUNT_EN is defined.
interface pc_fetch_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        resume;
  logic [31:0] inc_d;
  logic [31:0] inc_q;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic [31:0] pc;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count;
  modport master (
    input  stall, redirect_valid, redirect_pc, halt, resume, inc_q, imem_ack,
    output inc_d, imem_req, imem_addr, instr_valid, instr_pc, pc, fetch_count
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, halt, resume, inc_q, imem_ack,
    input  inc_d, imem_req, imem_addr, instr_valid, instr_pc, pc, fetch_count
  );
`else
  modport master (
    input  stall, redirect_valid, redirect_pc, halt, resume, inc_q, imem_ack,
    output inc_d, imem_req, imem_addr, instr_valid, instr_pc, pc
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, halt, resume, inc_q, imem_ack,
    input  inc_d, imem_req, imem_addr, instr_valid, instr_pc, pc
  );
`endif
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: MIPS fetch PC sequencer with req/ack imem handshake, stall, redirect and halt/resume.
// Define FETCH_COUNT_EN to add the fetch_count output (accepted-fetch counter).
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  pc_fetch_if.master bus
);
  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;
  logic [1:0]  state, state_nx;
  logic [31:0] pc_r, instr_pc_r;
  logic        instr_valid_r, redirect, accept;
  assign redirect = state != S_RESET && bus.redirect_valid;
  // an ack in the redirect cycle belongs to the squashed path and is dropped
  assign accept   = state == S_FETCH && bus.imem_ack && !bus.redirect_valid;
  always_comb begin
    state_nx = state == S_RESET ? S_FETCH :
               redirect         ? (state == S_HALT ? S_HALT : S_FETCH) :
               bus.halt         ? S_HALT :
               state == S_HALT  ? (bus.resume ? S_FETCH : S_HALT) :
               bus.stall        ? S_HOLD : S_FETCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_RESET;
      pc_r          <= RESET_VECTOR;
      instr_valid_r <= 1'b0;
      instr_pc_r    <= '0;
    end else begin
      state         <= state_nx;
      instr_valid_r <= accept;
      pc_r          <= redirect ? bus.redirect_pc : accept ? bus.inc_q : pc_r;
      if (accept) instr_pc_r <= pc_r;
    end
  end
  assign bus.imem_req    = state == S_FETCH;
  assign bus.imem_addr   = pc_r;
  assign bus.inc_d       = pc_r;
  assign bus.pc          = pc_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.instr_pc    = instr_pc_r;
`ifdef FETCH_COUNT_EN
  logic [31:0] fetch_count_r;
  always_ff @(posedge clk) begin
    if (rst) fetch_count_r <= '0;
    else if (accept) fetch_count_r <= fetch_count_r + 32'd1;
  end
  assign bus.fetch_count = fetch_count_r;
`endif
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: random + directed stimulus against a behavioural fetch model with an instr_pc scoreboard.
module tb_pc_fetch_sequencer;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
  logic clk = 1'b0, rst = 1'b1;
  pc_fetch_if bus ();
  pc_fetch_sequencer #(.RESET_VECTOR(RV)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  assign bus.inc_q = bus.inc_d + 32'd1;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 0;
  int m_mode = M_IDLE;
  logic [31:0] m_pc = RV, m_cnt = 0;
  logic exp_req = 0, exp_valid = 0;
  logic [31:0] exp_pc = RV;
  logic [31:0] sb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (chk_on) begin
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    chk("imem_addr", bus.imem_addr, exp_pc);
    chk("pc", bus.pc, exp_pc);
    chk("inc_d", bus.inc_d, exp_pc);
    chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, exp_valid});
`ifdef FETCH_COUNT_EN
    chk("fetch_count", bus.fetch_count, m_cnt);
`endif
    if (bus.instr_valid === 1'b1) begin
      if (sb.size() == 0) chk("instr_pc_extra", bus.instr_pc, 32'hxxxx_xxxx);
      else chk("instr_pc", bus.instr_pc, sb.pop_front());
    end
  end
  // one clock of stimulus; the model advances on the same edge the DUT samples
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rp,
                      input logic h, input logic rs, input logic a);
    rst = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rp;
    bus.halt = h; bus.resume = rs; bus.imem_ack = a;
    exp_req = m_mode == M_RUN;
    exp_pc  = m_pc;
    @(posedge clk);
    exp_valid = 0;
    if (r) begin
      m_mode = M_IDLE; m_pc = RV; m_cnt = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_RUN;
    end else if (rv) begin
      m_pc = rp;
      if (m_mode != M_HALT) m_mode = M_RUN;
    end else begin
      if (m_mode == M_RUN && a) begin
        sb.push_back(m_pc);
        m_pc = m_pc + 1;
        m_cnt = m_cnt + 1;
        exp_valid = 1;
      end
      if (h) m_mode = M_HALT;
      else if (m_mode == M_HALT) m_mode = rs ? M_RUN : M_HALT;
      else m_mode = s ? M_WAIT : M_RUN;
    end
    #1;
  endtask
  task automatic run(input int n, input logic a);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk_on = 1;
    chk("rst_instr_pc", bus.instr_pc, 32'd0);
    chk("rst_state_req", {31'd0, bus.imem_req}, 32'd0);
    run(5, 1);
    run(3, 0);
    run(2, 1);
    step(0, 0, 1, 32'h40, 0, 0, 1);
    run(3, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    run(3, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h10, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    run(2, 1);
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 0, 0);
    run(5, 1);
    run(2, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    chk("rst_mid_pc", bus.pc, RV);
    run(3, 1);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, rp,
           $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 65);
    end
    run(2, 0);
    chk("sb_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
